branch_redirect_ctrl: RTL
=========================

Name: branch_redirect_ctrl

Overview:
- Consumer of the branch-taken signal, i.e. the branch control AND'ed with the comparator-equal output.
- Owns the fetch PC: sequential increment, hold on hazard stall, redirect to the branch target on a taken branch.
- On a redirect, squashes the wrong-path instruction in IF/ID by driving a registered flush.
- Sits between the ID-stage branch logic / hazard unit and the IF-stage instruction memory address.

Parameters:
- ADDR_W, 32, PC and target width in bits.
- RESET_PC, 0, PC value loaded on reset.
- INSTR_BYTES, 4, PC increment per sequential fetch (power of two).
- FLUSH_CYCLES, 1, cycles flush_if_id stays high after a redirect (1..7).
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk, in, 1, system clock; all state updates on the rising edge.
- rst_n, in, 1, synchronous active-low reset.
- br_taken, in, 1, branch taken (branch control AND comparator equal).
- br_target, in, ADDR_W, branch target address, valid when br_taken=1.
- stall, in, 1, hazard-unit stall; holds the PC.
- pc_o, out, ADDR_W, current fetch address to instruction memory.
- pc_write, out, 1, combinational; 1 when the PC will update at the next edge.
- flush_if_id, out, 1, registered; clears the IF/ID register.
- redirect_pulse, out, 1, registered; one-cycle pulse after a redirect is taken.
- br_count, out, CNT_W, number of accepted redirects, saturating.
- misalign_err, out, 1, sticky; set when an accepted target is not INSTR_BYTES-aligned.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n), sampled only on the rising clk edge.
- Reset values: pc_o=RESET_PC, flush_if_id=0, redirect_pulse=0, br_count=0, misalign_err=0, state=S_RUN, flush counter=0.
- Reset mid-flush: abandons the flush immediately, with no residual flush cycle.
- FSM has two states, S_RUN and S_FLUSH.
- S_RUN priority 1, stall=1:
  - PC holds, pc_write=0.
  - br_taken is ignored, because operands are not final while ID is stalled.
- S_RUN priority 2, br_taken=1:
  - pc_o <= br_target with the low log2(INSTR_BYTES) bits forced to 0.
  - flush_if_id <= 1, redirect_pulse <= 1, flush counter <= FLUSH_CYCLES-1.
  - br_count increments unless it is all-ones.
  - misalign_err is set if any forced bit was 1.
  - Next state is S_FLUSH, or S_RUN with flush held exactly one cycle when FLUSH_CYCLES=1.
- S_RUN priority 3, otherwise: pc_o <= pc_o + INSTR_BYTES, modulo 2^ADDR_W (wraps from all-ones-minus-3 to 0), pc_write=1.
- S_FLUSH:
  - flush_if_id stays 1; the counter decrements each cycle. At counter 0, flush_if_id <= 0 and state <= S_RUN.
  - The PC keeps advancing sequentially from the target unless stall=1. A stall also freezes the flush counter, so the flush length counts only non-stalled cycles.
  - br_taken is ignored, since the ID-stage instruction is a squashed bubble.
- Latency:
  - br_taken sampled at edge N makes pc_o=target visible after edge N.
  - flush_if_id is high from edge N for FLUSH_CYCLES non-stalled cycles.
  - redirect_pulse is high exactly one cycle, after edge N.
- Simultaneous br_taken and stall: stall wins, no redirect and no count. The branch re-presents once the stall drops.
- br_target equal to the current pc_o is a legal self-loop: it is a redirect and is counted.
- br_count saturates at 2^CNT_W-1.
- misalign_err clears only on reset.

Decomposition:
- Shared package pipe_pkg holds:
  - the state typedef {S_RUN, S_FLUSH};
  - the ADDR_W default;
  - INSTR_BYTES and its log2 constant;
  - RESET_PC.
- One natural sub-module, sat_counter (CNT_W-bit saturating incrementer with enable), to be reused by other pipeline performance counters.
- The PC register and FSM stay in branch_redirect_ctrl.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles, then release with no branch. Require pc_o sequence 0, 4, 8, 12; flush_if_id=0; br_count=0.
2. Taken branch: at pc_o=0x10, assert br_taken=1 with br_target=0x40 for 1 cycle. Require:
   - next pc_o=0x40, then 0x44;
   - flush_if_id=1 for 1 cycle, redirect_pulse=1 for 1 cycle;
   - br_count=1.
3. Stall priority: assert stall=1 and br_taken=1 (target 0x80) together for 2 cycles, then br_taken alone. Require:
   - pc_o frozen during the stall, no flush, br_count unchanged;
   - redirect to 0x80 on the cycle after the stall drops.
4. FLUSH_CYCLES=3 with br_taken pulsed again during the flush. Require flush_if_id high 3 cycles, the second br_taken ignored, and br_count incremented by only 1.
5. Misaligned target: br_target=0x23. Require pc_o=0x20 and misalign_err=1, still 1 after 10 further cycles; it clears only on rst_n=0.
6. Wrap and saturation, with pc_o preloaded via branch to 0xFFFF_FFFC and CNT_W=2:
   - require pc_o to wrap to 0x0000_0000;
   - after 5 redirects, require br_count=3 (saturated);
   - assert rst_n=0 during a flush and require flush_if_id=0 on the next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch-control FSM states and default fetch geometry.
package pipe_pkg;

    typedef enum logic {
        S_RUN,
        S_FLUSH
    } state_e;

    localparam int unsigned      DEF_ADDR_W      = 32;
    localparam int unsigned      DEF_INSTR_BYTES = 4;
    localparam int unsigned      DEF_INSTR_LSB   = $clog2(DEF_INSTR_BYTES);
    localparam logic [31:0]      DEF_RESET_PC    = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && !(&count_q)) begin
            count_d = count_q + Width'(1);
        end
    end

    // Synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Fetch PC owner: sequential advance, stall hold, and taken-branch redirect with
// a registered IF/ID flush that lasts FLUSH_CYCLES non-stalled cycles.
module branch_redirect_ctrl #(
    parameter int unsigned       ADDR_W       = pipe_pkg::DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC     = ADDR_W'(pipe_pkg::DEF_RESET_PC),
    parameter int unsigned       INSTR_BYTES  = pipe_pkg::DEF_INSTR_BYTES,
    parameter int unsigned       FLUSH_CYCLES = 1,
    parameter int unsigned       CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_write,
    output logic              flush_if_id,
    output logic              redirect_pulse,
    output logic [CNT_W-1:0]  br_count,
    output logic              misalign_err
);

    import pipe_pkg::*;

    localparam logic [ADDR_W-1:0] LowMask = ADDR_W'(INSTR_BYTES - 1);
    localparam logic [ADDR_W-1:0] PcInc   = ADDR_W'(INSTR_BYTES);
    localparam logic [2:0]        FlushInit = 3'(FLUSH_CYCLES - 1);

    state_e            state_q, state_d;
    logic [2:0]        fcnt_q, fcnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              flush_q, flush_d;
    logic              pulse_q, pulse_d;
    logic              misalign_q, misalign_d;
    logic              cnt_en;

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        pc_d       = pc_q;
        flush_d    = flush_q;
        pulse_d    = 1'b0;
        misalign_d = misalign_q;
        cnt_en     = 1'b0;
        pc_write   = 1'b0;

        unique case (state_q)
            S_RUN: begin
                flush_d = 1'b0;
                // A stall masks br_taken: ID operands are not final yet.
                if (stall) begin
                    pc_write = 1'b0;
                end else if (br_taken) begin
                    pc_d       = br_target & ~LowMask;
                    pc_write   = 1'b1;
                    flush_d    = 1'b1;
                    pulse_d    = 1'b1;
                    fcnt_d     = FlushInit;
                    cnt_en     = 1'b1;
                    misalign_d = misalign_q | (|(br_target & LowMask));
                    state_d    = (FLUSH_CYCLES == 1) ? S_RUN : S_FLUSH;
                end else begin
                    pc_d     = pc_q + PcInc;
                    pc_write = 1'b1;
                end
            end
            S_FLUSH: begin
                // The ID instruction is a squashed bubble, so br_taken is ignored here.
                if (!stall) begin
                    pc_d     = pc_q + PcInc;
                    pc_write = 1'b1;
                    if (fcnt_q == 3'd0) begin
                        flush_d = 1'b0;
                        state_d = S_RUN;
                    end else begin
                        fcnt_d = fcnt_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            fcnt_q     <= 3'd0;
            pc_q       <= RESET_PC;
            flush_q    <= 1'b0;
            pulse_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            pc_q       <= pc_d;
            flush_q    <= flush_d;
            pulse_q    <= pulse_d;
            misalign_q <= misalign_d;
        end
    end

    sat_counter #(
        .Width(CNT_W)
    ) u_br_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (cnt_en),
        .count_o(br_count)
    );

    assign pc_o           = pc_q;
    assign flush_if_id    = flush_q;
    assign redirect_pulse = pulse_q;
    assign misalign_err   = misalign_q;

endmodule
